// File: rtl/mips_isa_pkg.sv
// MIPS ISA encodings used by the front end.
//   OPCODE_WIDTH : width of the primary opcode field instr[31:26]
//   opcode_e     : primary opcodes recognised by fetch
package mips_isa_pkg;

    localparam int unsigned OPCODE_WIDTH = 6;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        RType = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03
    } opcode_e;

endpackage : mips_isa_pkg

// File: rtl/mips_pkg.sv
// Shared core parameters and the fetch-unit state encoding.
//   PC_WIDTH / INSTR_WITDTH : datapath widths of the fetch front end
//   COUNT_WIDTH             : width of the accepted-instruction counter
//   RESET_PC_DEFAULT        : default first fetch address
//   fetch_state_e           : BOOT / RUN / HOLD
package mips_pkg;

    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned INSTR_WITDTH = 32;
    localparam int unsigned COUNT_WIDTH  = 32;

    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, IF/ID handshake, redirect input
// and the accepted-instruction counter.
//   master : the fetch unit (drives pc, if_*, fetch_count)
//   slave  : memory / decode / execute side
interface mips_fetch_unit_if
    import mips_pkg::*;
();

    logic [PC_WIDTH-1:0]     pc;
    logic [INSTR_WITDTH-1:0] instr;
    logic [INSTR_WITDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]     if_pc_plus4;
    logic                    if_valid;
    logic                    id_ready;
    logic                    redirect_valid;
    logic [PC_WIDTH-1:0]     redirect_target;
    logic [COUNT_WIDTH-1:0]  fetch_count;

    modport master (
        output pc, if_instr, if_pc_plus4, if_valid, fetch_count,
        input  instr, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  pc, if_instr, if_pc_plus4, if_valid, fetch_count,
        output instr, id_ready, redirect_valid, redirect_target
    );

endinterface : mips_fetch_unit_if

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: redirect, then J/JAL, then pc+4.
//   pc_i              : current fetch address
//   instr_i           : word fetched at pc_i
//   redirect_valid_i  : execute redirect request
//   redirect_target_i : redirect address (low two bits ignored)
//   next_pc_c_o       : selected next fetch address
module mips_next_pc
    import mips_pkg::*;
    import mips_isa_pkg::*;
(
    input  logic [PC_WIDTH-1:0]     pc_i,
    input  logic [INSTR_WITDTH-1:0] instr_i,
    input  logic                    redirect_valid_i,
    input  logic [PC_WIDTH-1:0]     redirect_target_i,
    output logic [PC_WIDTH-1:0]     next_pc_c_o
);

    logic [PC_WIDTH-1:0]     pc_plus4;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    is_jump;

    always_comb begin
        pc_plus4    = pc_i + PC_WIDTH'(4);
        opcode      = instr_i[31:26];
        is_jump     = (opcode == J) || (opcode == JAL);
        next_pc_c_o = pc_plus4;
        if (redirect_valid_i) begin
            // Mask rather than slice so every target bit is consumed.
            next_pc_c_o = redirect_target_i & ~PC_WIDTH'(3);
        end else if (is_jump) begin
            next_pc_c_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
        end
    end

endmodule : mips_next_pc

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC register, BOOT/RUN/HOLD control, IF/ID
// output stage with valid/ready handshake, and accepted-instruction counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch bus (master side), see mips_fetch_unit_if
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_fetch_unit_if.master  bus
);

    fetch_state_e            state_q;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [PC_WIDTH-1:0]     pc_d;
    logic [INSTR_WITDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]     pc_plus4_q;
    logic                    valid_q;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic                    advance;
    logic                    accept;

    mips_next_pc u_next_pc (
        .pc_i              (pc_q),
        .instr_i           (bus.instr),
        .redirect_valid_i  (bus.redirect_valid),
        .redirect_target_i (bus.redirect_target),
        .next_pc_c_o       (pc_d)
    );

    // Output stage may load when empty or when decode drains it this edge.
    assign advance = !valid_q || bus.id_ready;
    // A redirect squashes the output word, so it is never counted.
    assign accept  = valid_q && bus.id_ready && !bus.redirect_valid;

    // Control FSM, PC, IF/ID stage and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN, HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        state_q <= RUN;
                    end else if (advance) begin
                        instr_q    <= bus.instr;
                        pc_plus4_q <= pc_q + PC_WIDTH'(4);
                        valid_q    <= 1'b1;
                        pc_q       <= pc_d;
                        state_q    <= RUN;
                    end else begin
                        state_q <= HOLD;
                    end
                    if (accept) begin
                        count_q <= count_q + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc_plus4 = pc_plus4_q;
    assign bus.if_valid    = valid_q;
    assign bus.fetch_count = count_q;

endmodule : mips_fetch_unit

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: reset/boot, sequential fetch, J,
// backpressure hold, redirect squash in HOLD, PC wrap, mid-stream reset.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    mips_fetch_unit_if bus ();

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: J 0x40 at 0x10, otherwise {addi opcode, addr[27:2]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return {6'h02, 26'h000_0040};
        return {6'h08, a[27:2]};
    endfunction

    always_comb bus.instr = mem_word(bus.pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL rst_pc: got %h exp %h", bus.pc, 32'h0); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h0) $display("FAIL rst_instr: got %h exp 0", bus.if_instr); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h0) $display("FAIL rst_pc4: got %h exp 0", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'h0) $display("FAIL rst_count: got %0d exp 0", bus.fetch_count); else n_pass++;
        n_total++; if (dut.state_q !== BOOT) $display("FAIL rst_state: got %0d exp BOOT", dut.state_q); else n_pass++;
        rst_n = 1'b1;
        tick(); // E0
        n_total++; if (bus.pc !== 32'h0) $display("FAIL boot_pc: got %h exp 0", bus.pc); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL boot_valid: got %b exp 0", bus.if_valid); else n_pass++;
        tick(); // E1
        n_total++; if (bus.if_instr !== 32'h2000_0000) $display("FAIL e1_instr: got %h exp %h", bus.if_instr, 32'h2000_0000); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h4) $display("FAIL e1_pc4: got %h exp 4", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL e1_valid: got %b exp 1", bus.if_valid); else n_pass++;
        n_total++; if (bus.pc !== 32'h4) $display("FAIL e1_pc: got %h exp 4", bus.pc); else n_pass++;
        tick(); // E2
        n_total++; if (bus.pc !== 32'h8) $display("FAIL e2_pc: got %h exp 8", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd1) $display("FAIL e2_count: got %0d exp 1", bus.fetch_count); else n_pass++;
        tick(); // E3
        n_total++; if (bus.pc !== 32'hC) $display("FAIL e3_pc: got %h exp c", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd2) $display("FAIL e3_count: got %0d exp 2", bus.fetch_count); else n_pass++;
    endtask

    task automatic test_jump();
        tick(); // E4: fetch address reaches the J word
        n_total++; if (bus.pc !== 32'h10) $display("FAIL j_pre_pc: got %h exp 10", bus.pc); else n_pass++;
        tick(); // E5: J captured, target presented
        n_total++; if (bus.if_instr !== 32'h0800_0040) $display("FAIL j_instr: got %h exp %h", bus.if_instr, 32'h0800_0040); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h14) $display("FAIL j_pc4: got %h exp 14", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.pc !== 32'h100) $display("FAIL j_target: got %h exp 100", bus.pc); else n_pass++;
        tick(); // E6: target word with no bubble
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL j_nobubble: got %b exp 1", bus.if_valid); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h2000_0040) $display("FAIL j_tgt_instr: got %h exp %h", bus.if_instr, 32'h2000_0040); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h104) $display("FAIL j_tgt_pc4: got %h exp 104", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd5) $display("FAIL j_count: got %0d exp 5", bus.fetch_count); else n_pass++;
    endtask

    task automatic test_hold();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_001C;
        tick(); // E7: steer so that pc = 0x20 while holding
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL steer_valid: got %b exp 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd5) $display("FAIL steer_count: got %0d exp 5", bus.fetch_count); else n_pass++;
        tick(); // E8
        n_total++; if (bus.pc !== 32'h20) $display("FAIL hold_pre_pc: got %h exp 20", bus.pc); else n_pass++;
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.pc !== 32'h20) $display("FAIL hold_pc[%0d]: got %h exp 20", i, bus.pc); else n_pass++;
            n_total++; if (bus.if_instr !== 32'h2000_0007) $display("FAIL hold_instr[%0d]: got %h exp %h", i, bus.if_instr, 32'h2000_0007); else n_pass++;
            n_total++; if (bus.if_pc_plus4 !== 32'h20) $display("FAIL hold_pc4[%0d]: got %h exp 20", i, bus.if_pc_plus4); else n_pass++;
            n_total++; if (bus.if_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b exp 1", i, bus.if_valid); else n_pass++;
            n_total++; if (dut.state_q !== HOLD) $display("FAIL hold_state[%0d]: got %0d exp HOLD", i, dut.state_q); else n_pass++;
        end
        n_total++; if (bus.fetch_count !== 32'd5) $display("FAIL hold_count: got %0d exp 5", bus.fetch_count); else n_pass++;
        bus.id_ready = 1'b1;
        tick(); // E12: release
        n_total++; if (bus.fetch_count !== 32'd6) $display("FAIL rel_count: got %0d exp 6", bus.fetch_count); else n_pass++;
        n_total++; if (bus.pc !== 32'h24) $display("FAIL rel_pc: got %h exp 24", bus.pc); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h2000_0008) $display("FAIL rel_instr: got %h exp %h", bus.if_instr, 32'h2000_0008); else n_pass++;
        n_total++; if (dut.state_q !== RUN) $display("FAIL rel_state: got %0d exp RUN", dut.state_q); else n_pass++;
    endtask

    task automatic test_redirect_in_hold();
        bus.id_ready = 1'b0;
        tick(); // E13
        n_total++; if (dut.state_q !== HOLD) $display("FAIL rh_state: got %0d exp HOLD", dut.state_q); else n_pass++;
        // Redirect together with id_ready: redirect wins, nothing counted.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0203;
        bus.id_ready        = 1'b1;
        tick(); // E14
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL rh_bubble: got %b exp 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.pc !== 32'h200) $display("FAIL rh_pc: got %h exp 200", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd6) $display("FAIL rh_count: got %0d exp 6", bus.fetch_count); else n_pass++;
        tick(); // E15
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL rh_valid: got %b exp 1", bus.if_valid); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h2000_0080) $display("FAIL rh_instr: got %h exp %h", bus.if_instr, 32'h2000_0080); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h204) $display("FAIL rh_pc4: got %h exp 204", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd6) $display("FAIL rh_count2: got %0d exp 6", bus.fetch_count); else n_pass++;
    endtask

    task automatic test_wrap();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        tick(); // E16
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pre_pc: got %h exp fffffffc", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd6) $display("FAIL wrap_count: got %0d exp 6", bus.fetch_count); else n_pass++;
        tick(); // E17
        n_total++; if (bus.pc !== 32'h0) $display("FAIL wrap_pc: got %h exp 0", bus.pc); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h exp 0", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h23FF_FFFF) $display("FAIL wrap_instr: got %h exp %h", bus.if_instr, 32'h23FF_FFFF); else n_pass++;
        tick(); // E18
        n_total++; if (bus.pc !== 32'h4) $display("FAIL wrap_next: got %h exp 4", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'd7) $display("FAIL wrap_count2: got %0d exp 7", bus.fetch_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL ar_pc: got %h exp 0", bus.pc); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL ar_valid: got %b exp 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.if_instr !== 32'h0) $display("FAIL ar_instr: got %h exp 0", bus.if_instr); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h0) $display("FAIL ar_pc4: got %h exp 0", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.fetch_count !== 32'h0) $display("FAIL ar_count: got %0d exp 0", bus.fetch_count); else n_pass++;
        n_total++; if (dut.state_q !== BOOT) $display("FAIL ar_state: got %0d exp BOOT", dut.state_q); else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(); // E0
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL ar_boot_valid: got %b exp 0", bus.if_valid); else n_pass++;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL ar_boot_pc: got %h exp 0", bus.pc); else n_pass++;
        tick(); // E1
        n_total++; if (bus.if_instr !== 32'h2000_0000) $display("FAIL ar_e1_instr: got %h exp %h", bus.if_instr, 32'h2000_0000); else n_pass++;
        n_total++; if (bus.if_pc_plus4 !== 32'h4) $display("FAIL ar_e1_pc4: got %h exp 4", bus.if_pc_plus4); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL ar_e1_valid: got %b exp 1", bus.if_valid); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n               = 1'b0;
        bus.id_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        test_reset();
        test_jump();
        test_hold();
        test_redirect_in_hold();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mips_fetch_unit

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch front end of the MIPS core. Owns the program counter and drives `pc` to the instruction memory, which returns `instr` combinationally in the same cycle. Registers the fetched word into an IF/ID output stage with a valid/ready handshake toward decode. Resolves J/JAL targets locally and accepts PC redirects from execute for branches, JR and JALR.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `PC_WIDTH`, `INSTR_WITDTH`: taken from `mips_pkg`, not overridden locally; both 32.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  out  PC_WIDTH  fetch address to instruction memory; resets to RESET_PC.
- `instr`  in  INSTR_WITDTH  memory read data for `pc`, valid in the same cycle.
- `if_instr`  out  INSTR_WITDTH  registered instruction; resets to 0.
- `if_pc_plus4`  out  PC_WIDTH  address of `if_instr` + 4, used as the link value; resets to 0.
- `if_valid`  out  1  `if_instr` is valid; resets to 0.
- `id_ready`  in  1  decode accepts `if_instr` this cycle.
- `redirect_valid`  in  1  single-cycle pulse from execute.
- `redirect_target`  in  PC_WIDTH  new PC; bits [1:0] are forced to 0.
- `fetch_count`  out  32  count of instructions accepted by decode; resets to 0 and wraps.

## Operation
- The core has no branch delay slots.
- State BOOT is entered on reset. It lasts exactly 1 cycle after `rst_n` rises, then the unit goes to RUN. In BOOT: `pc`=RESET_PC and `if_valid`=0.
- `advance` = RUN && (!if_valid || id_ready).
- On advance:
  - `if_instr` <= `instr`
  - `if_pc_plus4` <= `pc`+4
  - `if_valid` <= 1
  - `pc` <= next_pc
- next_pc priority:
  1. `redirect_valid`: `{redirect_target[31:2],2'b00}`.
  2. `instr` opcode is J or JAL (`mips_isa_pkg`): `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  3. Otherwise `pc`+4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- Redirect squash: on `redirect_valid`, the word fetched this cycle is wrong-path.
  - `if_valid` <= 0 next cycle.
  - `pc` <= target.
  - This applies in RUN and in HOLD; a held instruction is dropped.
  - A redirect in BOOT is ignored.
- RUN → HOLD when `if_valid` && !`id_ready` && !`redirect_valid`. In HOLD, `pc`, `if_instr` and `if_pc_plus4` are frozen.
- HOLD → RUN when `id_ready`=1 (the held word is consumed and the next word captured in the same edge) or when `redirect_valid`=1.
- `fetch_count` increments on every `if_valid && id_ready` edge where `redirect_valid`=0.
- Asynchronous reset at any time returns every output to its reset value immediately. No partial state survives.

## Timing
- Reset release edge E0: BOOT.
- E1: first capture of mem[RESET_PC]; `if_valid`=1 after E1.
- Latency from `pc` presented to `if_valid`: 1 cycle.
- Throughput: 1 instruction per cycle while `id_ready`=1.
- J/JAL penalty: 0 cycles. The target is fetched on the cycle after the jump is captured.
- Redirect penalty: 1 bubble. `if_valid`=0 for exactly one cycle, then the target instruction appears.
- `redirect_valid` and `id_ready` high together: the redirect wins, the output is squashed, and `fetch_count` does not increment.
- Handshake rule: `if_instr` and `if_pc_plus4` are stable while `if_valid` && !`id_ready`.

## Structure
- `mips_pkg`: `PC_WIDTH`, `INSTR_WITDTH`, default `RESET_PC`, and the fetch state enum `fetch_state_e` {BOOT, RUN, HOLD}.
- `mips_isa_pkg`: the existing opcode enum (J, JAL, RType); no new entries.
- Sub-module `mips_next_pc`: combinational. Inputs are `pc`, `instr`, `redirect_valid`, `redirect_target`. Output is next_pc. It is shared with later branch-prediction work.
- Top level holds the state FSM, PC register, output register and counter.

## Test plan
- Reset with RESET_PC=0: `pc`=0 and `if_valid`=0 during BOOT. After E1, `if_instr`=mem[0] and `if_pc_plus4`=4. Then `pc` steps 4, 8, 12 with `id_ready`=1.
- `instr`=J with target field 0x0000040 at `pc`=0x10: next `pc`=0x100. The J word itself is delivered with `if_pc_plus4`=0x14, with no bubble.
- `id_ready`=0 for 3 cycles at `pc`=0x20: `pc` and `if_instr` are frozen and the state is HOLD. On release, `fetch_count` increments by 1 and `pc`=0x24.
- `redirect_valid` with target 0x203 while in HOLD: the held word is dropped, `if_valid`=0 for 1 cycle, then `if_instr`=mem[0x200] and `fetch_count` is unchanged.
- `pc`=0xFFFF_FFFC with a sequential instruction: next `pc`=0x0000_0000.
- `rst_n` asserted mid-stream between edges: all outputs show their reset values immediately, and the BOOT sequence restarts.
